// File: rtl/lane_serial_tx.sv
// lane_serial_tx
// ---------------------------------------------------------------------------
// Transmit end of the per-lane bit path. Parallel WIDTH-bit words are
// pushed into a small holding FIFO. They are serialised one bit per enabled
// clock on o_sd. o_sof flags the first bit of each word in serial order.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_en     serial advance enable (word acceptance is not gated by it)
//   i_valid  a word is offered on i_a
//   i_a      parallel word
//   o_ready  FIFO can accept a word (not full)
//   o_sd     serial data bit (registered)
//   o_sv     o_sd is valid this cycle (registered)
//   o_sof    o_sd is the first serial bit of a word (registered)
//   o_busy   a word is still in flight or the FIFO holds words
// ---------------------------------------------------------------------------
module lane_serial_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DEPTH     = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_ready,
    output logic             o_sd,
    output logic             o_sv,
    output logic             o_sof,
    output logic             o_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int REM_W = $clog2(WIDTH);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [REM_W-1:0] FIRST_REM = REM_W'(WIDTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             sd_q, sd_d;
    logic             sv_q, sv_d;
    logic             sof_q, sof_d;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [WIDTH-1:0] head;

    // Bit that leaves the word first in the configured serial order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with the emitted bit removed, so the next bit sits in the same slot.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // o_ready is derived from the registered count only. A pop at the same
    // edge therefore never opens a slot for a push while the FIFO is full.
    assign fifo_empty = (count_q == '0);
    assign o_ready    = (count_q != FULL_CNT);
    assign push       = i_valid && o_ready;
    assign pop        = i_en && (rem_q == '0) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q];
    assign o_busy     = (rem_q != '0) || !fifo_empty;

    assign o_sd  = sd_q;
    assign o_sv  = sv_q;
    assign o_sof = sof_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        sd_d     = sd_q;
        sv_d     = 1'b0;
        sof_d    = 1'b0;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The popped word's first bit goes out on the same edge that loads
        // it. Back-to-back words therefore have no idle gap between them.
        if (i_en) begin
            if (rem_q != '0) begin
                sd_d    = first_bit(shift_q);
                shift_d = advance(shift_q);
                sv_d    = 1'b1;
                rem_d   = rem_q - REM_W'(1);
            end else if (!fifo_empty) begin
                sd_d    = first_bit(head);
                shift_d = advance(head);
                sv_d    = 1'b1;
                sof_d   = 1'b1;
                rem_d   = FIRST_REM;
            end
        end
    end

    // Storage needs no reset: the cleared pointers and count make it empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_a;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            rem_q    <= '0;
            sd_q     <= 1'b0;
            sv_q     <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            rem_q    <= rem_d;
            sd_q     <= sd_d;
            sv_q     <= sv_d;
            sof_q    <= sof_d;
        end
    end

endmodule
